// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map, condition codes, FSM states
// and the architectural flag word.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_ADC  = 5'd2,
        OP_SBC  = 5'd3,
        OP_INC  = 5'd20,
        OP_DEC  = 5'd21,
        OP_AND  = 5'd22,
        OP_NAND = 5'd23,
        OP_OR   = 5'd24,
        OP_XOR  = 5'd25,
        OP_SHL  = 5'd26,
        OP_SHR  = 5'd27,
        OP_SAR  = 5'd28,
        OP_MUL  = 5'd29,
        OP_DIVU = 5'd30,
        OP_REMU = 5'd31
    } op_e;

    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_Z  = 3'd1,
        COND_NZ = 3'd2,
        COND_C  = 3'd3,
        COND_NC = 3'd4
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    // Opcodes below this value carry a condition field in op[4:2].
    localparam logic [4:0] OP_COND_LIMIT = 5'd20;

    function automatic logic cond_true(input cond_e cond, input flags_t f);
        cond_true = 1'b1;
        case (cond)
            COND_Z:  cond_true = f.z;
            COND_NZ: cond_true = ~f.z;
            COND_C:  cond_true = f.c;
            COND_NC: cond_true = ~f.c;
            default: cond_true = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle,
// sharing a single accumulator / shift-register pair.
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_div;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // Multiply: {acc,q} holds the partial product, multiplier bits leave q from the bottom.
    assign w_add   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    // Divide: acc is the partial remainder, dividend bits leave q from the top.
    // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_fits  = w_shift >= {1'b0, r_m};
    assign w_diff  = WIDTH'(w_shift - {1'b0, r_m});

    always_comb begin
        if (r_div) begin
            w_acc_nxt = w_fits ? w_diff : w_shift[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], w_fits};
        end else begin
            w_acc_nxt = w_add[WIDTH:1];
            w_q_nxt   = {w_add[0], r_q[WIDTH-1:1]};
        end
    end

    // Results are taken from the next-state values so the final iteration edge
    // and the result capture edge coincide.
    assign o_done = r_busy && (r_count == CW'(WIDTH - 1));
    assign o_lo   = w_q_nxt;
    assign o_hi   = w_acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_div   <= 1'b0;
            r_count <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_div   <= i_div;
            r_count <= '0;
            r_acc   <= '0;
            r_q     <= i_div ? i_a : i_b;
            r_m     <= i_div ? i_b : i_a;
        end else if (r_busy) begin
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_count <= r_count + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle adder/logic/shifter, iterative mul/div,
// registered result and architectural flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             conditionMet,
    output logic             zeroFlag,
    output logic             carryFlag,
    output logic             negFlag,
    output logic             ovfFlag
);

    localparam int SHW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_nxt;
    state_e           w_start_state;
    flags_t           r_flags;
    flags_t           w_single_flags;
    flags_t           w_md_flags;
    logic [WIDTH-1:0] r_result;
    logic             r_cond_met;
    logic             r_is_rem;
    logic             r_b_zero;

    logic             w_accept;
    logic             w_in_ready;
    logic             w_is_multi;
    logic             w_cin;
    logic             w_sum_ovf;
    logic             w_cond_met;
    logic             w_md_done;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_single_res;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_res;

    assign w_in_ready = ~flush && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && outReady));
    assign w_accept   = inValid && w_in_ready;
    assign w_is_multi = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    assign w_start_state = !w_is_multi ? ST_DONE : ((op == OP_MUL) ? ST_MUL : ST_DIV);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_b_eff = b;
        w_cin   = 1'b0;
        if (op < OP_COND_LIMIT) begin
            w_b_eff = op[0] ? ~b : b;
            w_cin   = op[1] ? r_flags.c : op[0];
        end else if (op == OP_INC) begin
            w_cin = 1'b1;
        end else if (op == OP_DEC) begin
            w_b_eff = ~b;
        end
    end

    assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    assign w_sum_ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sh      = b[SHW-1:0];

    always_comb begin
        w_single_res   = w_sum[WIDTH-1:0];
        w_single_flags = r_flags;
        w_cond_met     = 1'b1;
        case (op)
            OP_AND:  w_single_res = a & b;
            OP_NAND: w_single_res = ~(a & b);
            OP_OR:   w_single_res = a | b;
            OP_XOR:  w_single_res = a ^ b;
            OP_SHL:  w_single_res = a << w_sh;
            OP_SHR:  w_single_res = a >> w_sh;
            OP_SAR:  w_single_res = $signed(a) >>> w_sh;
            default: begin
                w_single_flags.c = w_sum[WIDTH];
                w_single_flags.v = w_sum_ovf;
                if (op < OP_COND_LIMIT) begin
                    w_cond_met = cond_true(cond_e'(op[4:2]), r_flags);
                end
            end
        endcase
        w_single_flags.z = (w_single_res == '0);
        w_single_flags.n = w_single_res[WIDTH-1];
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept && w_is_multi),
        .i_abort (flush),
        .i_div   (op != OP_MUL),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_md_done),
        .o_lo    (w_md_lo),
        .o_hi    (w_md_hi)
    );

    always_comb begin
        w_md_res     = r_is_rem ? w_md_hi : w_md_lo;
        w_md_flags.z = (w_md_res == '0);
        w_md_flags.c = (r_state == ST_MUL) ? (w_md_hi != '0) : r_b_zero;
        w_md_flags.n = w_md_res[WIDTH-1];
        w_md_flags.v = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_start_state;
            ST_MUL,
            ST_DIV:  if (w_md_done) w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_start_state;
                end else if (outReady) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_cond_met <= 1'b0;
            r_flags    <= '0;
            r_is_rem   <= 1'b0;
            r_b_zero   <= 1'b0;
        end else if (!flush) begin
            if (w_accept && !w_is_multi) begin
                r_result   <= w_single_res;
                r_cond_met <= w_cond_met;
                if (w_cond_met) begin
                    r_flags <= w_single_flags;
                end
            end else if (w_accept) begin
                r_cond_met <= 1'b1;
                r_is_rem   <= (op == OP_REMU);
                r_b_zero   <= (b == '0);
            end else if (w_md_done) begin
                r_result <= w_md_res;
                r_flags  <= w_md_flags;
            end
        end
    end

    assign inReady      = w_in_ready;
    assign outValid     = (r_state == ST_DONE);
    assign result       = r_result;
    assign conditionMet = r_cond_met;
    assign zeroFlag     = r_flags.z;
    assign carryFlag    = r_flags.c;
    assign negFlag      = r_flags.n;
    assign ovfFlag      = r_flags.v;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed test-plan steps, then random
// ops against an arithmetic reference model of the opcode rules.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  op;
    logic        outValid;
    logic        outReady;
    logic [15:0] result;
    logic        conditionMet;
    logic        zeroFlag;
    logic        carryFlag;
    logic        negFlag;
    logic        ovfFlag;

    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  mf = 4'b0000;   // model flags {z,c,n,v}

    alu_seq #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .inValid      (inValid),
        .inReady      (inReady),
        .a            (a),
        .b            (b),
        .op           (op),
        .outValid     (outValid),
        .outReady     (outReady),
        .result       (result),
        .conditionMet (conditionMet),
        .zeroFlag     (zeroFlag),
        .carryFlag    (carryFlag),
        .negFlag      (negFlag),
        .ovfFlag      (ovfFlag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the opcode rules using plain integer arithmetic.
    function automatic void model(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                                  input logic [3:0] fin, output logic [15:0] r,
                                  output logic met, output logic [3:0] fout);
        longint s, be, sx, sbe, ss, p;
        int     cin, sh;
        bit     sub;
        logic   z, c, n, v;
        {z, c, n, v} = fin;
        met = 1'b1;
        r   = '0;
        sub = 1'b0;
        cin = 0;
        if (o <= 21) begin
            if (o < 20) begin
                sub = (o % 2) == 1;
                cin = (o % 4 == 0) ? 0 : (o % 4 == 1) ? 1 : int'(c);
                case (o / 4)
                    0:       met = 1'b1;
                    1:       met = z;
                    2:       met = !z;
                    3:       met = c;
                    default: met = !c;
                endcase
            end else begin
                sub = (o == 21);
                cin = (o == 20) ? 1 : 0;
            end
            be  = sub ? longint'(65535 - y) : longint'(y);
            s   = longint'(x) + be + cin;
            r   = s[15:0];
            sx  = (x >= 16'h8000) ? longint'(x) - 65536 : longint'(x);
            sbe = (be >= 32768) ? be - 65536 : be;
            ss  = sx + sbe + cin;
            if (met) begin
                c = (s >= 65536);
                v = (ss > 32767) || (ss < -32768);
            end
        end else if (o <= 28) begin
            sh = int'(y[3:0]);
            sx = (x >= 16'h8000) ? longint'(x) - 65536 : longint'(x);
            case (o)
                22:      r = x & y;
                23:      r = ~(x & y);
                24:      r = x | y;
                25:      r = x ^ y;
                26:      r = 16'(x << sh);
                27:      r = x >> sh;
                default: r = 16'(sx >>> sh);
            endcase
        end else if (o == 29) begin
            p = longint'(x) * longint'(y);
            r = p[15:0];
            c = (p >= 65536);
            v = 1'b0;
        end else begin
            if (y == 0) begin
                r = (o == 30) ? 16'hFFFF : x;
                c = 1'b1;
            end else begin
                r = (o == 30) ? x / y : x % y;
                c = 1'b0;
            end
            v = 1'b0;
        end
        if (met) begin
            z = (r == 16'h0000);
            n = r[15];
        end
        fout = {z, c, n, v};
    endfunction

    // Waits (bounded) for inReady at a negedge, presents the op, returns #1 after the accept edge.
    task automatic start_op(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y);
        int k = 0;
        while (!inReady && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("op%0d_in_ready", o), inReady, 1'b1);
        op = o;
        a = x;
        b = y;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                          input int hold);
        logic [15:0] er;
        logic        em;
        logic [3:0]  ef;
        int          lat, exp_lat;
        bit          busy_ready;
        string       tag;
        model(o, x, y, mf, er, em, ef);
        exp_lat = (o >= 29) ? 16 : 0;
        tag = $sformatf("op%0d_%04h_%04h", o, x, y);
        start_op(o, x, y);
        if (hold > 0) outReady = 1'b0;
        @(negedge clk);
        lat = 0;
        busy_ready = 1'b0;
        while (!outValid && lat < 40) begin
            if (inReady) busy_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_out_valid"}, outValid, 1'b1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_cond_met"}, conditionMet, em);
        chk({tag, "_flags_zcnv"}, {zeroFlag, carryFlag, negFlag, ovfFlag}, ef);
        if (exp_lat > 0) chk({tag, "_in_ready_while_busy"}, busy_ready, 1'b0);
        mf = ef;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, "_hold_valid"}, outValid, 1'b1);
                chk({tag, "_hold_result"}, result, er);
                chk({tag, "_hold_in_ready"}, inReady, 1'b0);
            end
            outReady = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_released"}, outValid, 1'b0);
        end
    endtask

    initial begin
        logic [4:0]  ro;
        logic [15:0] rx, ry;
        int          rh;
        bit          seen;

        rst = 1'b1;
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        a = '0;
        b = '0;
        op = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_out_valid", outValid, 1'b0);
        chk("reset_result", result, 16'h0000);
        chk("reset_cond_met", conditionMet, 1'b0);
        chk("reset_flags", {zeroFlag, carryFlag, negFlag, ovfFlag}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", inReady, 1'b1);

        // Add wrap, dependent conditional add, subtract overflow, failed conditional sbc
        run_op(5'd0, 16'hFFFF, 16'h0001, 0);
        chk("add_wrap_zero_explicit", {result, zeroFlag, carryFlag, ovfFlag}, {16'h0000, 3'b110});
        run_op(5'd4, 16'h0002, 16'h0003, 0);
        run_op(5'd1, 16'h8000, 16'h0001, 0);
        chk("sub_ovf_explicit", {result, carryFlag, negFlag, ovfFlag}, {16'h7FFF, 3'b101});
        run_op(5'd7, 16'h0005, 16'h0003, 0);
        chk("sbc_cond_false_explicit", {conditionMet, zeroFlag, carryFlag, negFlag, ovfFlag},
            5'b0_0101);

        // Multiply, divide, remainder, divide by zero
        run_op(5'd29, 16'h0100, 16'h0100, 0);
        chk("mul_explicit", {result, zeroFlag, carryFlag}, {16'h0000, 2'b11});
        run_op(5'd30, 16'h0064, 16'h0007, 0);
        chk("divu_explicit", result, 16'h000E);
        run_op(5'd31, 16'h0064, 16'h0007, 0);
        chk("remu_explicit", result, 16'h0002);
        run_op(5'd30, 16'h1234, 16'h0000, 0);
        chk("div0_explicit", {result, carryFlag}, {16'hFFFF, 1'b1});
        run_op(5'd31, 16'h1234, 16'h0000, 0);

        // Arithmetic shift right with consumer stall; carry must stay from previous op
        run_op(5'd28, 16'h8000, 16'h0004, 5);
        chk("sar_explicit", {result, carryFlag}, {16'hF800, 1'b1});
        run_op(5'd29, 16'h1234, 16'h00FF, 2);

        // Flush in the same cycle as inValid: no accept
        @(negedge clk);
        op = 5'd0;
        a = 16'h0001;
        b = 16'h0001;
        inValid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_with_valid_no_accept", outValid, 1'b0);
        chk("flush_with_valid_in_ready", inReady, 1'b1);

        // Flush mid-division
        start_op(5'd30, 16'h0064, 16'h0007);
        repeat (7) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", outValid, 1'b0);
        chk("flush_in_ready", inReady, 1'b1);
        chk("flush_flags_kept", {zeroFlag, carryFlag, negFlag, ovfFlag}, mf);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outValid) seen = 1'b1;
        end
        chk("flush_no_late_result", seen, 1'b0);

        // Reset mid-multiply
        start_op(5'd29, 16'h1234, 16'h5678);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", outValid, 1'b0);
        chk("rst_async_result", result, 16'h0000);
        chk("rst_async_cond_met", conditionMet, 1'b0);
        chk("rst_async_flags", {zeroFlag, carryFlag, negFlag, ovfFlag}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        mf = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outValid) seen = 1'b1;
        end
        chk("rst_no_late_result", seen, 1'b0);
        chk("rst_in_ready", inReady, 1'b1);

        // Random ops, back-to-back where no stall is drawn
        for (int i = 0; i < 60; i++) begin
            ro = 5'($urandom_range(0, 31));
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (ro >= 30 && $urandom_range(0, 3) == 0) ry = 16'($urandom_range(0, 9));
            rh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(ro, rx, ry, rh);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
